// File: rtl/id_scoreboard_if.sv
// Bundle of IDU / id_ex / WBU / redirect signals seen by the scoreboard.
// The scoreboard sits on the slave side; the surrounding pipeline drives
// the master side.
interface id_scoreboard_if #(
  parameter int NREG = 32,
  parameter int IF_W = 3
);
  // IDU side
  logic            d_valid_i;
  logic            d_ready_o;
  logic [4:0]      d_rs1_i;
  logic [4:0]      d_rs2_i;
  logic            d_ren_rs1_i;
  logic            d_ren_rs2_i;
  logic [4:0]      d_rd_i;
  logic            d_wenReg_i;
  logic            d_wenCsr_i;
  logic            d_renCsr_i;
  logic            d_serial_i;
  // id_ex side
  logic            x_valid_o;
  logic            x_ready_i;
  // writeback retire
  logic            w_valid_i;
  logic [4:0]      w_rd_i;
  logic            w_wenReg_i;
  logic            w_wenCsr_i;
  // redirect squash
  logic            k_valid_i;
  logic [4:0]      k_rd_i;
  logic            k_wenReg_i;
  logic            k_wenCsr_i;
  // status
  logic            stall_o;
  logic [NREG-1:0] busy_o;
  logic [IF_W-1:0] inflight_o;
  logic            err_o;

  modport slave (
    input  d_valid_i, d_rs1_i, d_rs2_i, d_ren_rs1_i, d_ren_rs2_i, d_rd_i,
           d_wenReg_i, d_wenCsr_i, d_renCsr_i, d_serial_i,
           x_ready_i,
           w_valid_i, w_rd_i, w_wenReg_i, w_wenCsr_i,
           k_valid_i, k_rd_i, k_wenReg_i, k_wenCsr_i,
    output d_ready_o, x_valid_o, stall_o, busy_o, inflight_o, err_o
  );

  modport master (
    output d_valid_i, d_rs1_i, d_rs2_i, d_ren_rs1_i, d_ren_rs2_i, d_rd_i,
           d_wenReg_i, d_wenCsr_i, d_renCsr_i, d_serial_i,
           x_ready_i,
           w_valid_i, w_rd_i, w_wenReg_i, w_wenCsr_i,
           k_valid_i, k_rd_i, k_wenReg_i, k_wenCsr_i,
    input  d_ready_o, x_valid_o, stall_o, busy_o, inflight_o, err_o
  );
endinterface

// File: rtl/id_scoreboard.sv
// RAW / structural hazard controller between the IDU and id_ex.
// Keeps a pending-write counter per integer register plus one for CSRs and
// a total in-flight count, and holds back the IDU->id_ex handshake while a
// source is pending, a counter would overflow, or a serializing instruction
// is waiting for an empty pipe. Hazards use registered state only, so a
// retire in the same cycle as a dependent read still stalls for one cycle.
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int IF_W  = 3
) (
  input logic            clk_i,
  input logic            rst_i,
  id_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IF_W-1:0]  IF_MAX  = '1;

  logic [CNT_W-1:0] cnt      [NREG];
  logic [CNT_W-1:0] cnt_next [NREG];
  logic [CNT_W-1:0] csr_cnt;
  logic [CNT_W-1:0] csr_next;
  logic [IF_W-1:0]  inflight;
  logic [IF_W-1:0]  inflight_next;
  logic             err;
  logic             err_next;

  logic             raw1;
  logic             raw2;
  logic             rawc;
  logic             full;
  logic             ser;
  logic             stall;
  logic             d_ready;
  logic             issue;
  logic [NREG-1:0]  busy;

  // Hazard detection and handshake gating from registered state only.
  always_comb begin
    raw1    = bus.d_ren_rs1_i && (bus.d_rs1_i != 5'd0) && (cnt[bus.d_rs1_i] != '0);
    raw2    = bus.d_ren_rs2_i && (bus.d_rs2_i != 5'd0) && (cnt[bus.d_rs2_i] != '0);
    rawc    = bus.d_renCsr_i && (csr_cnt != '0);
    full    = (bus.d_wenReg_i && (bus.d_rd_i != 5'd0) && (cnt[bus.d_rd_i] == CNT_MAX)) ||
              (bus.d_wenCsr_i && (csr_cnt == CNT_MAX)) ||
              (inflight == IF_MAX);
    ser     = bus.d_serial_i && (inflight != '0);
    stall   = bus.d_valid_i && (raw1 || raw2 || rawc || full || ser);
    d_ready = bus.x_ready_i && !stall;
    issue   = bus.d_valid_i && d_ready;
  end

  // Sum issue/retire/squash per counter; clamp and flag any under/overflow.
  always_comb begin : next_state
    int v;
    v             = 0;
    err_next      = err;
    csr_next      = csr_cnt;
    inflight_next = inflight;
    for (int r = 0; r < NREG; r++) begin
      cnt_next[r] = '0;
      if (r != 0) begin
        v = int'(cnt[r]);
        if (issue && bus.d_wenReg_i && (bus.d_rd_i == 5'(r))) v = v + 1;
        if (bus.w_valid_i && bus.w_wenReg_i && (bus.w_rd_i == 5'(r))) v = v - 1;
        if (bus.k_valid_i && bus.k_wenReg_i && (bus.k_rd_i == 5'(r))) v = v - 1;
        if (v < 0) begin
          cnt_next[r] = '0;
          err_next    = 1'b1;
        end else if (v > int'(CNT_MAX)) begin
          cnt_next[r] = CNT_MAX;
          err_next    = 1'b1;
        end else begin
          cnt_next[r] = CNT_W'(v);
        end
      end
    end

    v = int'(csr_cnt);
    if (issue && bus.d_wenCsr_i) v = v + 1;
    if (bus.w_valid_i && bus.w_wenCsr_i) v = v - 1;
    if (bus.k_valid_i && bus.k_wenCsr_i) v = v - 1;
    if (v < 0) begin
      csr_next = '0;
      err_next = 1'b1;
    end else if (v > int'(CNT_MAX)) begin
      csr_next = CNT_MAX;
      err_next = 1'b1;
    end else begin
      csr_next = CNT_W'(v);
    end

    v = int'(inflight);
    if (issue) v = v + 1;
    if (bus.w_valid_i) v = v - 1;
    if (bus.k_valid_i) v = v - 1;
    if (v < 0) begin
      inflight_next = '0;
      err_next      = 1'b1;
    end else if (v > int'(IF_MAX)) begin
      inflight_next = IF_MAX;
      err_next      = 1'b1;
    end else begin
      inflight_next = IF_W'(v);
    end
  end

  // State register; reset overrides any traffic in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      csr_cnt  <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_next[r];
      csr_cnt  <= csr_next;
      inflight <= inflight_next;
      err      <= err_next;
    end
  end

  // Per-register busy flags; x0 is never tracked.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) busy[r] = (cnt[r] != '0);
  end

  assign bus.stall_o    = stall;
  assign bus.d_ready_o  = d_ready;
  assign bus.x_valid_o  = bus.d_valid_i && !stall;
  assign bus.busy_o     = busy;
  assign bus.inflight_o = inflight;
  assign bus.err_o      = err;

endmodule

// File: tb/tb_id_scoreboard.sv
// Testbench for id_scoreboard: directed table of pipeline scenarios, a few
// hand-written error/reset sequences, then random traffic checked against
// a queue of in-flight instructions.
module tb_id_scoreboard;

  localparam int NREG    = 32;
  localparam int CNT_W   = 2;
  localparam int IF_W    = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int IF_MAX  = (1 << IF_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  id_scoreboard_if #(.NREG(NREG), .IF_W(IF_W)) bus ();

  id_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .IF_W(IF_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit          dv;
    logic [4:0]  rs1;
    bit          r1;
    logic [4:0]  rs2;
    bit          r2;
    logic [4:0]  rd;
    bit          wr;
    bit          wc;
    bit          rc;
    bit          ser;
    bit          xr;
    bit          wv;
    logic [4:0]  wrd;
    bit          wwr;
    bit          wwc;
    bit          kv;
    logic [4:0]  krd;
    bit          kwr;
    bit          kwc;
    bit          e_stall;
    bit          e_xv;
    bit          e_dr;
    int          e_if;
    logic [31:0] e_busy;
    bit          e_err;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    bit         wreg;
    bit         wcsr;
  } ent_t;

  ent_t q[$];
  vec_t tbl[$];

  localparam logic [31:0] B5 = 32'h20;
  localparam logic [31:0] B6 = 32'h40;
  localparam logic [31:0] B7 = 32'h80;

  function automatic vec_t mk(bit dv, int rs1, bit r1, int rs2, bit r2, int rd, bit wr,
                              bit ser, bit xr, bit wv, int wrd,
                              bit es, bit ex, bit ed, int eif, logic [31:0] eb);
    vec_t v;
    v.dv = dv;   v.rs1 = 5'(rs1); v.r1 = r1; v.rs2 = 5'(rs2); v.r2 = r2;
    v.rd = 5'(rd); v.wr = wr; v.wc = 1'b0; v.rc = 1'b0; v.ser = ser; v.xr = xr;
    v.wv = wv; v.wrd = 5'(wrd); v.wwr = wv; v.wwc = 1'b0;
    v.kv = 1'b0; v.krd = 5'd0; v.kwr = 1'b0; v.kwc = 1'b0;
    v.e_stall = es; v.e_xv = ex; v.e_dr = ed; v.e_if = eif; v.e_busy = eb; v.e_err = 1'b0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.d_valid_i   = v.dv;
    bus.d_rs1_i     = v.rs1;
    bus.d_ren_rs1_i = v.r1;
    bus.d_rs2_i     = v.rs2;
    bus.d_ren_rs2_i = v.r2;
    bus.d_rd_i      = v.rd;
    bus.d_wenReg_i  = v.wr;
    bus.d_wenCsr_i  = v.wc;
    bus.d_renCsr_i  = v.rc;
    bus.d_serial_i  = v.ser;
    bus.x_ready_i   = v.xr;
    bus.w_valid_i   = v.wv;
    bus.w_rd_i      = v.wrd;
    bus.w_wenReg_i  = v.wwr;
    bus.w_wenCsr_i  = v.wwc;
    bus.k_valid_i   = v.kv;
    bus.k_rd_i      = v.krd;
    bus.k_wenReg_i  = v.kwr;
    bus.k_wenCsr_i  = v.kwc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRow(input vec_t v, input string tag);
    checkOutput({tag, ".stall"},    32'(bus.stall_o),    32'(v.e_stall));
    checkOutput({tag, ".x_valid"},  32'(bus.x_valid_o),  32'(v.e_xv));
    checkOutput({tag, ".d_ready"},  32'(bus.d_ready_o),  32'(v.e_dr));
    checkOutput({tag, ".busy"},     32'(bus.busy_o),     v.e_busy);
    checkOutput({tag, ".inflight"}, 32'(bus.inflight_o), 32'(v.e_if));
    checkOutput({tag, ".err"},      32'(bus.err_o),      32'(v.e_err));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Pending register writes implied by the in-flight queue.
  function automatic int cntReg(logic [4:0] r);
    int k = 0;
    foreach (q[i]) if (q[i].wreg && q[i].rd == r) k++;
    return k;
  endfunction

  function automatic int cntCsr();
    int k = 0;
    foreach (q[i]) if (q[i].wcsr) k++;
    return k;
  endfunction

  function automatic logic [31:0] busyModel();
    logic [31:0] b = '0;
    for (int r = 1; r < NREG; r++) b[r] = (cntReg(5'(r)) > 0);
    return b;
  endfunction

  task automatic applyReset();
    applyStimulus(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0,0));
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    vec_t v;
    bit   st;
    int   n;

    // dv rs1 r1 rs2 r2 rd wr ser xr | wv wrd | stall xv dr inflight busy
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0, 0,0,1, 0, 0));
    tbl.push_back(mk(1,0,1,0,0,5,1,0,1, 0,0, 0,1,1, 0, 0));
    tbl.push_back(mk(1,5,1,0,1,6,1,0,1, 0,0, 1,0,0, 1, B5));
    tbl.push_back(mk(1,5,1,0,1,6,1,0,1, 0,0, 1,0,0, 1, B5));
    tbl.push_back(mk(1,5,1,0,1,6,1,0,1, 1,5, 1,0,0, 1, B5));
    tbl.push_back(mk(1,5,1,0,1,6,1,0,1, 0,0, 0,1,1, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,7,1,0,1, 0,0, 0,1,1, 1, B6));
    tbl.push_back(mk(1,0,0,0,0,7,1,0,1, 0,0, 0,1,1, 2, B6|B7));
    tbl.push_back(mk(1,0,0,0,0,7,1,0,1, 1,7, 0,1,1, 3, B6|B7));
    tbl.push_back(mk(1,0,0,0,0,7,1,0,1, 0,0, 0,1,1, 3, B6|B7));
    tbl.push_back(mk(1,0,0,0,0,7,1,0,1, 0,0, 1,0,0, 4, B6|B7));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 1,6, 0,0,1, 4, B6|B7));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 1,7, 0,0,1, 3, B7));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,1, 1,7, 1,0,0, 2, B7));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,1, 1,7, 1,0,0, 1, B7));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,1, 0,0, 0,1,1, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 1,0, 0,0,1, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0, 0,0,1, 0, 0));
    tbl.push_back(mk(1,0,1,0,1,0,1,0,0, 0,0, 0,1,0, 0, 0));
    tbl.push_back(mk(1,0,1,0,1,0,1,0,1, 0,0, 0,1,1, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 1,0, 0,0,1, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0, 0,0,1, 0, 0));

    applyReset();

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #4;
      checkRow(tbl[i], $sformatf("tbl%0d", i));
      nextCycle();
    end

    // Retire and squash of the same single x9 write underflows.
    applyStimulus(mk(1,0,0,0,0,9,1,0,1, 0,0, 0,0,0, 0, 0));
    #4;
    checkOutput("x9_issue.d_ready", 32'(bus.d_ready_o), 32'd1);
    nextCycle();
    v = mk(0,0,0,0,0,0,0,0,1, 1,9, 0,0,0, 0, 0);
    v.kv = 1'b1; v.krd = 5'd9; v.kwr = 1'b1;
    applyStimulus(v);
    #4;
    checkOutput("x9_pre.busy", 32'(bus.busy_o), 32'h200);
    checkOutput("x9_pre.err",  32'(bus.err_o),  32'd0);
    nextCycle();
    applyStimulus(mk(0,0,0,0,0,0,0,0,1, 0,0, 0,0,0, 0, 0));
    #4;
    checkOutput("x9_post.busy",     32'(bus.busy_o),     32'd0);
    checkOutput("x9_post.inflight", 32'(bus.inflight_o), 32'd0);
    checkOutput("x9_post.err",      32'(bus.err_o),      32'd1);
    for (int i = 0; i < 3; i++) nextCycle();
    checkOutput("err_sticky", 32'(bus.err_o), 32'd1);

    // Reset in the middle of traffic wins over a same-cycle issue.
    applyStimulus(mk(1,0,0,0,0,3,1,0,1, 0,0, 0,0,0, 0, 0));
    nextCycle();
    applyStimulus(mk(1,0,0,0,0,4,1,0,1, 0,0, 0,0,0, 0, 0));
    rst = 1'b1;
    #4;
    checkOutput("pre_rst.busy", 32'(bus.busy_o), 32'h8);
    nextCycle();
    rst = 1'b0;
    applyStimulus(mk(0,0,0,0,0,0,0,0,1, 0,0, 0,0,0, 0, 0));
    #4;
    checkOutput("rst.busy",     32'(bus.busy_o),     32'd0);
    checkOutput("rst.inflight", 32'(bus.inflight_o), 32'd0);
    checkOutput("rst.err",      32'(bus.err_o),      32'd0);
    nextCycle();
    q.delete();

    // Random traffic against the in-flight queue model.
    for (int c = 0; c < 1500; c++) begin
      v = mk(0,0,0,0,0,0,0,0,0, 0,0, 0,0,0, 0, 0);
      v.dv  = ($urandom_range(99) < 75);
      v.rs1 = 5'($urandom_range(7));
      v.r1  = 1'($urandom_range(1));
      v.rs2 = 5'($urandom_range(7));
      v.r2  = 1'($urandom_range(1));
      v.rd  = 5'($urandom_range(7));
      v.wr  = 1'($urandom_range(1));
      v.wc  = ($urandom_range(99) < 20);
      v.rc  = ($urandom_range(99) < 20);
      v.ser = ($urandom_range(99) < 8);
      v.xr  = ($urandom_range(99) < 80);
      n = q.size();
      if (n > 0 && $urandom_range(99) < 40) begin
        v.wv = 1'b1; v.wrd = q[0].rd; v.wwr = q[0].wreg; v.wwc = q[0].wcsr;
      end
      if (n > (v.wv ? 1 : 0) && $urandom_range(99) < 10) begin
        v.kv = 1'b1; v.krd = q[n-1].rd; v.kwr = q[n-1].wreg; v.kwc = q[n-1].wcsr;
      end

      st = (v.r1 && v.rs1 != 0 && cntReg(v.rs1) > 0) ||
           (v.r2 && v.rs2 != 0 && cntReg(v.rs2) > 0) ||
           (v.rc && cntCsr() > 0) ||
           (v.wr && v.rd != 0 && cntReg(v.rd) == CNT_MAX) ||
           (v.wc && cntCsr() == CNT_MAX) ||
           (n == IF_MAX) ||
           (v.ser && n != 0);
      v.e_stall = v.dv && st;
      v.e_xv    = v.dv && !st;
      v.e_dr    = v.xr && !v.e_stall;
      v.e_if    = n;
      v.e_busy  = busyModel();
      v.e_err   = 1'b0;

      applyStimulus(v);
      #4;
      checkRow(v, $sformatf("rnd%0d", c));
      nextCycle();

      if (v.kv) void'(q.pop_back());
      if (v.wv) void'(q.pop_front());
      if (v.dv && v.e_dr) q.push_back('{rd: v.rd, wreg: v.wr, wcsr: v.wc});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- RAW/structural hazard controller sitting between the IDU and the id_ex pipeline register.
- Tracks in-flight register and CSR writes with per-register pending counters.
- Gates the IDU→id_ex valid/ready handshake so an instruction is only issued when its sources are not pending and counters cannot overflow.
- Serializes system instructions (fence/ecall/mret) by draining the pipe before issue.

Parameters:
NREG, 32, number of architectural integer registers (x0 never tracked)
CNT_W, 2, width of each per-register pending counter (max 2^CNT_W-1 outstanding writes per rd)
IF_W, 3, width of total in-flight instruction counter (max 2^IF_W-1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
d_valid_i  in  1  IDU has a decoded instruction
d_ready_o  out  1  to IDU: instruction accepted this cycle
d_rs1_i  in  5  source 1 index
d_rs2_i  in  5  source 2 index
d_ren_rs1_i  in  1  instruction reads rs1
d_ren_rs2_i  in  1  instruction reads rs2
d_rd_i  in  5  destination index
d_wenReg_i  in  1  instruction writes rd
d_wenCsr_i  in  1  instruction writes a CSR
d_renCsr_i  in  1  instruction reads a CSR
d_serial_i  in  1  instruction must issue into an empty pipe
x_valid_o  out  1  to id_ex d_valid_i
x_ready_i  in  1  from id_ex E_ready_o
w_valid_i  in  1  WBU retires an instruction
w_rd_i  in  5  retiring rd
w_wenReg_i  in  1  retiring instruction wrote rd
w_wenCsr_i  in  1  retiring instruction wrote a CSR
k_valid_i  in  1  one in-flight instruction squashed (redirect)
k_rd_i  in  5  squashed rd
k_wenReg_i  in  1  squashed instruction had wenReg
k_wenCsr_i  in  1  squashed instruction had wenCsr
stall_o  out  1  hazard present on a valid IDU instruction
busy_o  out  NREG  bit r = register r counter nonzero (bit 0 always 0)
inflight_o  out  IF_W  current in-flight count
err_o  out  1  sticky underflow/overflow error

Behaviour:
- State: cnt[1..NREG-1] (CNT_W bits), csr_cnt (CNT_W), inflight (IF_W), err. All reset to 0 on rst_i; reset mid-operation clears all state next edge regardless of other inputs.
- Hazard (combinational from registered state only; same-cycle retire is NOT bypassed):
  - raw1 = d_ren_rs1_i & rs1!=0 & cnt[rs1]!=0; raw2 likewise for rs2.
  - rawc = d_renCsr_i & csr_cnt!=0.
  - full = (d_wenReg_i & rd!=0 & cnt[rd]==max) | (d_wenCsr_i & csr_cnt==max) | inflight==max.
  - ser = d_serial_i & inflight!=0.
  - stall_o = d_valid_i & (raw1|raw2|rawc|full|ser).
- Handshake: x_valid_o = d_valid_i & ~stall_o; d_ready_o = x_ready_i & ~stall_o. issue = d_valid_i & d_ready_o. x_valid_o must not depend on x_ready_i.
- Update per edge (independent sources summed, +1 issue, -1 retire, -1 kill):
  - cnt[r] += issue&wenReg&rd==r; -= w_valid&w_wenReg&w_rd==r; -= k_valid&k_wenReg&k_rd==r. Same for csr_cnt.
  - inflight += issue; -= w_valid_i; -= k_valid_i.
  - Simultaneous issue and retire on the same rd → net unchanged. Retire and kill on the same rd → -2.
  - rd==0 is never counted.
- Underflow (decrement below 0) → counter holds 0 and err sets. err clears only on reset. Overflow cannot occur via issue (blocked by full); err covers it defensively.
- Latency: busy_o/inflight_o reflect updates one cycle after the event.

Test Plan:
- Reset, then issue `addi x5` (wenReg, rd=5) with x_ready_i=1 → d_ready_o=1, next cycle busy_o[5]=1, inflight_o=1. Next cycle issue `add x6,x5,x0` → stall_o=1, x_valid_o=0 until w_valid_i with w_rd_i=5. The cycle after retire: stall_o=0, issue proceeds.
- Same-cycle retire of x5 and d_valid_i reading x5 → stall_o=1 that cycle (no bypass); issues the following cycle.
- Issue three writers to x7 (CNT_W=2) → cnt=3; a fourth writer to x7 → stall_o=1 (full). Issue+retire of x7 in the same cycle at cnt=2 → cnt stays 2.
- Two instructions in flight, d_serial_i=1 → stalled. Retire both → inflight_o=0, serial issues next cycle.
- Kill x9 (cnt=1) while retiring x9 in the same cycle → cnt holds 0, err_o=1 and stays 1 until rst_i. Assert rst_i mid-traffic → busy_o=0, inflight_o=0, err_o=0 next edge.
- Writes to x0 and reads of x0 → busy_o[0]=0 always, never stall; x_ready_i=0 → d_ready_o=0 while x_valid_o stays high, with no counter change.
